spi_master_xfer_ctrl: RTL

//  Sequences one SPI transaction on the spi_master_tx shifter: CMD, ADDR, DUMMY, then DATA phase.

---
 rtl/spi_master_xfer_ctrl.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_xfer_ctrl.sv
// Purpose: sequences one SPI transaction (CMD, ADDR, DUMMY, DATA) on the shifter, owning csn, busy and eot.
// Latency: start to first setup cycle 1 clk; each phase costs 1 setup clk plus shifter time; EOT adds 1 clk.
// Backpressure: words wait on tx_data_ready; a DATA underrun holds the phase with csn low until txf_valid returns.
`timescale 1ns/1ps
module spi_master_xfer_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] cfg_cmd,
    input  logic [5:0]  cfg_cmd_len,
    input  logic [31:0] cfg_addr,
    input  logic [5:0]  cfg_addr_len,
    input  logic [15:0] cfg_dummy_len,
    input  logic [15:0] cfg_data_len,
    input  logic        cfg_quad,
    input  logic [31:0] txf_data,
    input  logic        txf_valid,
    output logic        txf_ready,
    input  logic        tx_edge,
    input  logic        tx_done,
    input  logic        tx_data_ready,
    input  logic        tx_clk_en,
    output logic        tx_en,
    output logic        tx_en_quad,
    output logic [15:0] tx_counter,
    output logic        tx_counter_upd,
    output logic [31:0] tx_data,
    output logic        tx_data_valid,
    output logic        spi_clk_en,
    output logic        csn,
    output logic        busy,
    output logic        eot
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD_SETUP,
        S_CMD,
        S_ADDR_SETUP,
        S_ADDR,
        S_DUMMY,
        S_DATA_SETUP,
        S_DATA,
        S_EOT
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] cmd_q;
    logic [5:0]  cmd_len_q;
    logic [31:0] addr_q;
    logic [5:0]  addr_len_q;
    logic [15:0] dummy_len_q;
    logic [15:0] data_len_q;
    logic        quad_q;
    logic        csn_q;
    logic        busy_q;
    logic        word_sent_q;
    logic [15:0] dummy_cnt_q;

    logic        accept;
    logic [31:0] cmd_word;
    logic [31:0] addr_word;

    // Picks the first phase whose length is nonzero, in transaction order.
    // Callers zero the lengths of phases already done, so the same helper
    // serves the start decision and every phase exit.
    function automatic state_t first_phase(input logic [5:0]  c_len,
                                           input logic [5:0]  a_len,
                                           input logic [15:0] d_len,
                                           input logic [15:0] n_len);
        state_t nxt;
        if (c_len != 6'd0)
            nxt = S_CMD_SETUP;
        else if (a_len != 6'd0)
            nxt = S_ADDR_SETUP;
        else if (d_len != 16'd0)
            nxt = S_DUMMY;
        else if (n_len != 16'd0)
            nxt = S_DATA_SETUP;
        else
            nxt = S_EOT;
        return nxt;
    endfunction

    // Start is honoured only from IDLE, so a pulse while busy has no effect at all.
    assign accept = (state_q == S_IDLE) && start;

    // Command and address are right-aligned in config; the shifter wants them MSB-first.
    // A 32-bit length means the value already fills the word.
    assign cmd_word  = (cmd_len_q  >= 6'd32) ? cmd_q  : (cmd_q  << (6'd32 - cmd_len_q));
    assign addr_word = (addr_len_q >= 6'd32) ? addr_q : (addr_q << (6'd32 - addr_len_q));

    assign csn  = csn_q;
    assign busy = busy_q;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Capture the transaction config when a start is accepted; held for the whole transfer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_q       <= 32'd0;
            cmd_len_q   <= 6'd0;
            addr_q      <= 32'd0;
            addr_len_q  <= 6'd0;
            dummy_len_q <= 16'd0;
            data_len_q  <= 16'd0;
            quad_q      <= 1'b0;
        end else if (accept) begin
            cmd_q       <= cfg_cmd;
            cmd_len_q   <= cfg_cmd_len;
            addr_q      <= cfg_addr;
            addr_len_q  <= cfg_addr_len;
            dummy_len_q <= cfg_dummy_len;
            data_len_q  <= cfg_data_len;
            quad_q      <= cfg_quad;
        end
    end

    // Chip select and busy span from the accepted start through the EOT cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csn_q  <= 1'b1;
            busy_q <= 1'b0;
        end else if (accept) begin
            csn_q  <= 1'b0;
            busy_q <= 1'b1;
        end else if (state_q == S_EOT) begin
            csn_q  <= 1'b1;
            busy_q <= 1'b0;
        end
    end

    // CMD and ADDR each hand the shifter exactly one word; remember it was taken
    // so valid drops after the handshake. Re-armed in every setup cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            word_sent_q <= 1'b0;
        else if (state_q == S_CMD_SETUP || state_q == S_ADDR_SETUP)
            word_sent_q <= 1'b0;
        else if ((state_q == S_CMD || state_q == S_ADDR) && tx_data_valid && tx_data_ready)
            word_sent_q <= 1'b1;
    end

    // Dummy clock counter; only meaningful inside DUMMY, zero elsewhere.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            dummy_cnt_q <= 16'd0;
        else if (state_q != S_DUMMY)
            dummy_cnt_q <= 16'd0;
        else if (tx_edge)
            dummy_cnt_q <= dummy_cnt_q + 16'd1;
    end

    // Next-state and per-phase shifter controls. tx_done is the only exit from
    // shifting phases and tx_edge is only counted in DUMMY, so a coincident
    // done/edge pair can never advance twice or count an edge twice.
    always_comb begin
        state_d        = state_q;
        txf_ready      = 1'b0;
        tx_en          = 1'b0;
        tx_en_quad     = 1'b0;
        tx_counter     = 16'd0;
        tx_counter_upd = 1'b0;
        tx_data        = 32'd0;
        tx_data_valid  = 1'b0;
        spi_clk_en     = 1'b0;
        eot            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = first_phase(cfg_cmd_len, cfg_addr_len, cfg_dummy_len, cfg_data_len);
            end

            S_CMD_SETUP: begin
                tx_counter_upd = 1'b1;
                tx_counter     = {10'd0, cmd_len_q};
                state_d        = S_CMD;
            end

            S_CMD: begin
                tx_en         = 1'b1;
                tx_counter    = {10'd0, cmd_len_q};
                tx_data       = cmd_word;
                tx_data_valid = !word_sent_q;
                spi_clk_en    = tx_clk_en;
                if (tx_done)
                    state_d = first_phase(6'd0, addr_len_q, dummy_len_q, data_len_q);
            end

            S_ADDR_SETUP: begin
                tx_counter_upd = 1'b1;
                tx_counter     = {10'd0, addr_len_q};
                tx_en_quad     = quad_q;
                state_d        = S_ADDR;
            end

            S_ADDR: begin
                tx_en         = 1'b1;
                tx_en_quad    = quad_q;
                tx_counter    = {10'd0, addr_len_q};
                tx_data       = addr_word;
                tx_data_valid = !word_sent_q;
                spi_clk_en    = tx_clk_en;
                if (tx_done)
                    state_d = first_phase(6'd0, 6'd0, dummy_len_q, data_len_q);
            end

            S_DUMMY: begin
                // Shifter stays disabled; the clock generator runs free while edges are counted.
                spi_clk_en = 1'b1;
                tx_counter = dummy_len_q;
                if (tx_edge && (dummy_cnt_q + 16'd1 == dummy_len_q))
                    state_d = first_phase(6'd0, 6'd0, 16'd0, data_len_q);
            end

            S_DATA_SETUP: begin
                tx_counter_upd = 1'b1;
                tx_counter     = data_len_q;
                tx_en_quad     = quad_q;
                state_d        = S_DATA;
            end

            S_DATA: begin
                // FIFO feeds the shifter directly. On underrun the shifter drops its
                // clock request and keeps its bit count, so holding here with csn low
                // is enough to resume cleanly when the FIFO refills.
                tx_en         = 1'b1;
                tx_en_quad    = quad_q;
                tx_counter    = data_len_q;
                tx_data       = txf_data;
                tx_data_valid = txf_valid;
                txf_ready     = tx_data_ready;
                spi_clk_en    = tx_clk_en;
                if (tx_done)
                    state_d = S_EOT;
            end

            S_EOT: begin
                eot     = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
